// File: rtl/constant_port_arbiter.sv
// constant_port_arbiter
// Round-robin arbiter sharing the combinational constant-table ROM read port
// between NREQ requesters, with a one-entry response buffer tagged by the
// requester ID. Optional per-requester saturating grant counters are built
// when the macro CONST_ARB_STATS_EN is defined.
module constant_port_arbiter #(
    parameter int unsigned WORD = 16,
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [3*NREQ-1:0]    req_addr_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rsp_valid_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [WORD-1:0]      rsp_data_o,
    input  logic                 rsp_ready_i,
    output logic [2:0]           tbl_addr_o,
    input  logic [WORD-1:0]      tbl_data_i,
    input  logic [IDW-1:0]       stat_sel_i,
    output logic [15:0]          stat_cnt_o
);

    localparam int unsigned AW = 3;
    localparam int unsigned CW = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [IDW-1:0]   rsp_id_q;
    logic [WORD-1:0]  rsp_data_q;
    logic [AW-1:0]    last_addr_q;

    logic             grant_ok;
    logic             gnt_found;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_idx;
    logic [AW-1:0]    gnt_addr;
    int unsigned      cand;

    // A grant is possible with an empty buffer, or a full one being drained this cycle
    assign grant_ok  = rst_n_i && ((state_q == S_IDLE) || rsp_ready_i);
    assign gnt_valid = grant_ok && gnt_found;

    // Round-robin search from the pointer upward with wrap-around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            cand = 32'(ptr_q) + o;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!gnt_found && (k == cand) && req_valid_i[k]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = IDW'(k);
                end
            end
        end
    end

    // One-hot ready, granted address, ROM address and next pointer
    always_comb begin
        req_ready_o = '0;
        gnt_addr    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                req_ready_o[k] = gnt_valid;
                gnt_addr       = req_addr_i[3*k +: 3];
            end
        end
        tbl_addr_o = gnt_valid ? gnt_addr : last_addr_q;
        ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : IDW'(gnt_idx + IDW'(1));
    end

    // Buffer FSM: load on grant, drain to IDLE when consumed with no new grant
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            last_addr_q <= '0;
        end else if (gnt_valid) begin
            state_q     <= S_HOLD;
            ptr_q       <= ptr_d;
            rsp_id_q    <= gnt_idx;
            rsp_data_q  <= tbl_data_i;
            last_addr_q <= gnt_addr;
        end else if ((state_q == S_HOLD) && rsp_ready_i) begin
            state_q     <= S_IDLE;
        end
    end

    assign rsp_valid_o = (state_q == S_HOLD);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

`ifdef CONST_ARB_STATS_EN
    logic [CW-1:0] cnt_q [NREQ];

    // Saturating per-requester grant counters
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (gnt_valid && (gnt_idx == IDW'(k)) && (cnt_q[k] != {CW{1'b1}})) begin
                    cnt_q[k] <= cnt_q[k] + CW'(1);
                end
            end
        end
    end

    // Counter readback; out-of-range selects read 0
    always_comb begin
        stat_cnt_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (stat_sel_i == IDW'(k)) begin
                stat_cnt_o = cnt_q[k];
            end
        end
    end
`else
    logic unused_stat_sel;

    // Statistics not built: readback tied off
    assign unused_stat_sel = ^stat_sel_i;
    assign stat_cnt_o      = '0;
`endif

endmodule

// File: doc/constant_port_arbiter.md
Name: constant_port_arbiter

Overview:
Shares the single combinational read port of the constant table ROM between N requesters. Typical requesters are the operand fetch stage and the immediate/increment unit of the multi-cycle core. The block performs a round-robin grant with a valid/ready handshake and drives the ROM address. It registers the ROM data into a one-entry response buffer tagged with the requester ID. The ROM itself stays outside this block; the arbiter only sequences access to it.

Parameters:
WORD, 16, data width of the constant table and the response.
NREQ, 2, number of requesters; legal range 2..4.
IDW, 2, width of the requester ID; must satisfy 2**IDW >= NREQ.

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  reset, asynchronous assert, active-low.
req_valid_i  in  NREQ  per-requester lookup request.
req_addr_i  in  3*NREQ  per-requester constant index; requester k uses bits [3k+2:3k].
req_ready_o  out  NREQ  one-hot grant; the request is accepted in a cycle where valid and ready are both 1.
rsp_valid_o  out  1  response buffer holds valid data.
rsp_id_o  out  IDW  requester that owns the response.
rsp_data_o  out  WORD  constant value.
rsp_ready_i  in  1  consumer takes the response.
tbl_addr_o  out  3  to the constant table addr_i.
tbl_data_i  in  WORD  from the constant table data_o; combinational in tbl_addr_o.
stat_sel_i  in  IDW  grant-counter select (optional feature).
stat_cnt_o  out  16  grant count for the selected requester (optional feature).

Behaviour:
- Reset (async, rst_n_i=0):
  - rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0.
  - Round-robin pointer set to 0.
  - req_ready_o=0 while reset is asserted.
  - All grant counters cleared to 0.
- State machine, two states:
  - IDLE: buffer empty.
  - HOLD: buffer full.
- Grant eligibility: a grant is allowed when the state is IDLE, or when the state is HOLD and rsp_ready_i=1 in the same cycle (pass-through, full throughput).
- Grant choice:
  - Pick the first asserted req_valid_i, searching from the pointer upward with wrap-around.
  - Assert that requester's req_ready_o combinationally (one-hot); all other ready bits stay 0.
  - If no grant is allowed, or no request is valid, req_ready_o is all 0.
- ROM address:
  - tbl_addr_o = the granted requester's address.
  - When there is no grant, tbl_addr_o holds the last granted address; it is 0 after reset.
- On an accepted request (edge):
  - rsp_data_o <= tbl_data_i; rsp_id_o <= granted index; rsp_valid_o <= 1; state -> HOLD.
  - Pointer <= granted index + 1, wrapping modulo NREQ.
- Latency: exactly 1 clock from acceptance to rsp_valid_o.
- In HOLD with rsp_ready_i=0:
  - rsp_data_o and rsp_id_o are held stable.
  - No grant is made; the pointer is unchanged.
- In HOLD with rsp_ready_i=1:
  - If there is no new grant: rsp_valid_o <= 0; state -> IDLE.
  - If there is a new grant: the buffer is overwritten and stays in HOLD.
- rsp_ready_i is ignored while rsp_valid_o=0.
- Requesters must hold req_valid_i and req_addr_i stable until accepted. The arbiter does not latch unaccepted requests.
- Requester IDs >= NREQ never appear on rsp_id_o.
- Reset mid-transaction: the pending response is discarded and no partial grant survives.

Optional Feature:
Macro CONST_ARB_STATS_EN.
- Defined:
  - One 16-bit saturating grant counter per requester, incremented on each accepted request. The counter stops at 0xFFFF.
  - stat_cnt_o = counter[stat_sel_i], combinational.
  - stat_sel_i >= NREQ returns 0.
- Undefined:
  - No counters are synthesized.
  - stat_cnt_o is tied to 0 and stat_sel_i is unused.
  - Ports remain present so the interface is identical in both builds.

Test Plan:
- Reset, then pulse req_valid_i=01 with addr0=5 -> req_ready_o=01 in the same cycle; 1 clock later rsp_valid_o=1, rsp_id_o=0, rsp_data_o=0x0010.
- Both requesters valid continuously (addr0=7, addr1=1), rsp_ready_i=1 -> grants alternate 0,1,0,1; responses alternate 0xFFFF and 0x0001 with rsp_valid_o=1 every cycle.
- rsp_ready_i=0 for 3 cycles while both are valid -> req_ready_o=00, rsp_data_o stable; on release, the next grant goes to the requester after the last granted one.
- Only requester 1 valid, addr=6, rsp_ready_i=1 -> granted every cycle; the pointer wraps and requester 1 is still granted; rsp_data_o=0x0020.
- Assert rst_n_i low asynchronously while in HOLD -> rsp_valid_o=0 immediately, without waiting for a clock edge; after release, requester 0 has priority.
- With CONST_ARB_STATS_EN: 5 grants to requester 0 and 3 grants to requester 1 -> stat_sel_i=0 reads 5, stat_sel_i=1 reads 3, stat_sel_i=3 reads 0. Without the macro -> stat_cnt_o=0 always.
